// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO and re-presents its words as a valid/ready stream via a 2-entry skid buffer.
// Optional m_last framing output is enabled by defining FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned COUNT_WIDTH = 32
`ifdef FIFO_STREAM_READER_LAST_EN
    ,
    parameter int unsigned FRAME_LEN   = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       fifo_q,
    input  logic                   fifo_empty,
    output logic                   fifo_pop,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
`ifdef FIFO_STREAM_READER_LAST_EN
    output logic                   m_last,
`endif
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                   occ, occ_next;
    logic                   pend;
    logic [WIDTH-1:0]       buf0, buf0_next;
    logic [WIDTH-1:0]       buf1, buf1_next;
    logic [COUNT_WIDTH-1:0] word_count_next;
    logic                   take;
    logic [1:0]             occ_after_take;
    logic [1:0]             level;

    assign m_valid = (occ != OCC_0);
    assign m_data  = buf0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= OCC_0;
            pend       <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
            word_count <= '0;
        end else begin
            occ        <= occ_next;
            pend       <= fifo_pop;
            buf0       <= buf0_next;
            buf1       <= buf1_next;
            word_count <= word_count_next;
        end
    end

    // Occupancy bookkeeping: take frees the head, the in-flight word lands in the first free slot.
    always_comb begin
        occ_next        = occ;
        buf0_next       = buf0;
        buf1_next       = buf1;
        word_count_next = word_count;
        take            = 1'b0;
        occ_after_take  = 2'(occ);
        level           = 2'(occ);
        fifo_pop        = 1'b0;

        take           = m_valid && m_ready;
        occ_after_take = 2'(occ) - 2'(take);
        level          = occ_after_take + 2'(pend);
        fifo_pop       = !rst && !fifo_empty && (level < 2'd2);

        if (take) begin
            buf0_next       = buf1;
            word_count_next = word_count + COUNT_WIDTH'(1);
        end

        if (pend) begin
            if (occ_after_take == 2'd0) begin
                buf0_next = fifo_q;
            end else begin
                buf1_next = fifo_q;
            end
        end

        case (level)
            2'd0:    occ_next = OCC_0;
            2'd1:    occ_next = OCC_1;
            default: occ_next = OCC_2;
        endcase
    end

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int unsigned FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FRAME_W-1:0] frame_cnt, frame_cnt_next;

    assign m_last = m_valid && (frame_cnt == FRAME_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt_next;
        end
    end

    // Position within the frame advances per delivered word and restarts after the last one.
    always_comb begin
        frame_cnt_next = frame_cnt;
        if (take) begin
            frame_cnt_next = m_last ? '0 : frame_cnt + FRAME_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO in front of it.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned COUNT_WIDTH = 32;

    logic                   clk;
    logic                   rst;
    logic [WIDTH-1:0]       fifo_q;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [WIDTH-1:0]       m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [COUNT_WIDTH-1:0] word_count;
`ifdef FIFO_STREAM_READER_LAST_EN
    logic                   m_last;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] fifo_mem[$];
    logic [WIDTH-1:0] sb_q[$];
    bit               sb_en = 1'b0;
    int               pop_cnt = 0;
    int               take_cnt = 0;

    fifo_stream_reader #(
        .WIDTH      (WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
`ifdef FIFO_STREAM_READER_LAST_EN
        ,
        .FRAME_LEN  (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_q    (fifo_q),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef FIFO_STREAM_READER_LAST_EN
        .m_last    (m_last),
`endif
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Registered-read FIFO model plus pop/handshake counters.
    assign fifo_empty = (fifo_mem.size() == 0);

    initial fifo_q = '0;

    always @(posedge clk) begin
        if (rst) begin
            pop_cnt  = 0;
            take_cnt = 0;
        end else begin
            if (fifo_pop && fifo_mem.size() != 0) begin
                fifo_q <= fifo_mem.pop_front();
                pop_cnt++;
            end
            if (m_valid && m_ready) take_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_empty) check_eq("pop_while_empty", 32'(fifo_pop), 32'd0);
            check_eq("inflight_le2", 32'((pop_cnt - take_cnt) <= 2), 32'd1);
            if (sb_en && m_valid && m_ready) begin
                if (sb_q.size() == 0) check_eq("sb_extra_word", 32'(sb_q.size()), 32'd1);
                else check_eq("sb_data", 32'(m_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fifo_mem.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_words(input int n, input bit to_sb);
        for (int k = 1; k <= n; k++) begin
            fifo_mem.push_back(WIDTH'(k));
            if (to_sb) sb_q.push_back(WIDTH'(k));
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;

        // Reset with a non-empty FIFO: no pops while rst, clean outputs afterwards.
        fifo_mem.push_back(4'hA);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_pop", 32'(fifo_pop), 32'd0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_data", 32'(m_data), 32'd0);
        check_eq("rst_count", word_count, 32'd0);
        step();

        // Streaming: word k is valid in cycle k+1, pops in cycles 0..7.
        apply_reset();
        push_words(8, 1'b0);
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("st_pop", 32'(fifo_pop), 32'(c < 8));
            check_eq("st_valid", 32'(m_valid), 32'(c >= 2 && c < 10));
            if (c >= 2 && c < 10) check_eq("st_data", 32'(m_data), 32'(c - 1));
`ifdef FIFO_STREAM_READER_LAST_EN
            check_eq("st_last", 32'(m_last), 32'(c == 5 || c == 9));
`endif
            step();
        end
        check_eq("st_count", word_count, 32'd8);

        // Stall: only two words leave the FIFO, head held, then gapless drain.
        apply_reset();
        push_words(8, 1'b0);
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) step();
        @(negedge clk);
        check_eq("stall_pops", 32'(pop_cnt), 32'd2);
        check_eq("stall_pop_now", 32'(fifo_pop), 32'd0);
        check_eq("stall_valid", 32'(m_valid), 32'd1);
        check_eq("stall_data", 32'(m_data), 32'd1);
        step();
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq("drain_valid", 32'(m_valid), 32'd1);
            check_eq("drain_data", 32'(m_data), 32'(k));
            step();
        end
        @(negedge clk);
        check_eq("drain_idle", 32'(m_valid), 32'd0);
        check_eq("drain_count", word_count, 32'd8);
        step();

        // Alternating ready over 16 words, order checked by the scoreboard.
        apply_reset();
        sb_q.delete();
        push_words(16, 1'b1);
        sb_en   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 100 && take_cnt < 16; c++) begin
            step();
            m_ready = ~m_ready;
        end
        m_ready = 1'b0;
        step();
        sb_en = 1'b0;
        check_eq("alt_delivered", 32'(take_cnt), 32'd16);
        check_eq("alt_count", word_count, 32'd16);
        check_eq("alt_sb_left", 32'(sb_q.size()), 32'd0);

        // Mid-operation reset with two words buffered.
        apply_reset();
        push_words(8, 1'b0);
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check_eq("mid_count3", word_count, 32'd3);
        m_ready = 1'b0;
        step();
        check_eq("mid_buffered", 32'(pop_cnt - take_cnt), 32'd2);
        check_eq("mid_head", 32'(m_data), 32'd4);
        rst = 1'b1;
        fifo_mem.delete();
        step();
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_valid", 32'(m_valid), 32'd0);
        check_eq("mid_count0", word_count, 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            check_eq("mid_no_stale", 32'(m_valid), 32'd0);
        end
        step();
        fifo_mem.push_back(4'hC);
        @(negedge clk);
        check_eq("mid_new_lat0", 32'(m_valid), 32'd0);
        step();
        @(negedge clk);
        check_eq("mid_new_lat1", 32'(m_valid), 32'd0);
        step();
        @(negedge clk);
        check_eq("mid_new_valid", 32'(m_valid), 32'd1);
        check_eq("mid_new_data", 32'(m_data), 32'hC);
        step();

`ifdef FIFO_STREAM_READER_LAST_EN
        // Stall on the last word of a frame keeps m_last asserted until taken.
        apply_reset();
        push_words(8, 1'b0);
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("last_hold", 32'(m_last), 32'd1);
            check_eq("last_hold_data", 32'(m_data), 32'd4);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("last_take", 32'(m_last), 32'd1);
        step();
        @(negedge clk);
        check_eq("last_after", 32'(m_last), 32'd0);
        check_eq("last_after_data", 32'(m_data), 32'd5);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Sits directly downstream of the width-converting FIFO.
- Drives the FIFO's pop, absorbs its one-cycle registered read latency, and presents the narrow words as a valid/ready stream to the consumer (message-update datapath).
- Uses a 2-entry internal buffer so the consumer can stall without losing in-flight words, and sustains 1 word/cycle when unstalled.

Parameters:
- WIDTH, 4, data word width; equals the FIFO output width.
- COUNT_WIDTH, 32, width of the delivered-word counter.
- FRAME_LEN, 16, words per frame; used only with the optional feature; must be ≥ 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_q  input  WIDTH  FIFO read data; the word popped in cycle t is valid here in cycle t+1.
- fifo_empty  input  1  FIFO empty flag.
- fifo_pop  output  1  pop strobe to the FIFO.
- m_data  output  WIDTH  stream data; the head buffer entry.
- m_valid  output  1  stream valid.
- m_ready  input  1  consumer ready.
- word_count  output  COUNT_WIDTH  count of completed handshakes (m_valid && m_ready).

Behaviour:
- State is occ (buffered words, 0..2), pend (pop issued in the previous cycle, 1 bit), two entries buf0 (head) and buf1, and word_count.
- Reset (rst high at a clock edge): occ=0, pend=0, buf0=buf1=0, word_count=0. While rst is high, fifo_pop=0.
- After reset: m_valid=0, m_data=0.
- m_valid = (occ != 0). m_data = buf0.
- take = m_valid && m_ready.
- fifo_pop = !rst && !fifo_empty && (occ + pend - take) < 2.
  - This is combinational from m_ready and fifo_empty; fifo_pop is never asserted when fifo_empty=1.
- Capture: if pend=1 in cycle t, fifo_q in cycle t is written into the first free buffer slot after accounting for take.
- occ_next = occ + pend - take. pend_next = fifo_pop.
- Ordering:
  - On take, buf1 shifts to buf0.
  - A captured word goes to buf0 if the buffer becomes empty, otherwise to buf1.
  - Strict FIFO order is preserved.
- Latency: a word present in a non-empty FIFO with the reader idle and m_ready=1 appears with m_valid=1 two cycles after fifo_pop.
- Throughput: 1 word/cycle steady state with m_ready held high.
- Stall: with m_ready=0, at most 2 words are held (occ + pend ≤ 2 invariant); fifo_pop stays 0 until space frees.
- Simultaneous capture and take: occ unchanged; head advances; no bubble.
- fifo_empty rising after a pop: the in-flight word is still captured; no further pops.
- word_count increments by 1 on each take and wraps modulo 2^COUNT_WIDTH.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO shares rst and clears its pointers in the same cycle.
- m_data is don't-care-stable only while m_valid=1.
  - With m_valid=1 and m_ready=0, m_data and m_valid hold unchanged.

Optional Feature:
- Macro: FIFO_STREAM_READER_LAST_EN.
- Defined:
  - Adds output m_last (1 bit) and a frame counter (0..FRAME_LEN-1, reset 0).
  - m_last = m_valid && (frame counter == FRAME_LEN-1).
  - The counter increments on take and wraps to 0 after the take with m_last=1.
  - FRAME_LEN=1 makes m_last equal m_valid.
- Not defined: no m_last port, no frame counter; all other behaviour identical.

Test Plan:
- Reset then idle: assert rst 2 cycles with fifo_empty=0 -> fifo_pop=0 during rst; m_valid=0, m_data=0, word_count=0 on the cycle after rst deasserts.
- Streaming: FIFO preloaded with 0x1..0x8, m_ready=1 -> fifo_pop high 8 consecutive cycles; m_data sequence 1,2,...,8 on 8 consecutive valid cycles; word_count=8.
- Stall: 8 words queued, m_ready=0 for 10 cycles -> exactly 2 pops issued, m_data=1 held. Then m_ready=1 -> words 1..8 delivered in order with no gap, fifo_pop never high while fifo_empty=1.
- Alternating ready: m_ready toggles 1,0,1,0 over 16 words -> all 16 delivered in order, occ never exceeds 2, no word duplicated or lost.
- Mid-operation reset: rst for 1 cycle after 3 of 8 words are delivered, with 2 buffered -> m_valid=0 next cycle, word_count=0, no stale words appear afterwards.
- With FIFO_STREAM_READER_LAST_EN, FRAME_LEN=4, 8 words, m_ready=1 -> m_last high on words 4 and 8 only. A stall on word 4 holds m_last=1 until take.
